matrix_frame_scheduler: RTL

Sequences the SPI/shift-register output stage of the LED-matrix chain. It walks a completed frame in the pixel frame buffer column by column and word by word. For each word it drives the per-channel data words and the `new_image` / `new_column` / `data_valid` / `extra_bit` strobes, then waits for the output stage's `next_data` and `tx_finish` handshakes. It sits between the frame buffer (written by the color batch path) and the output module, and owns all frame/column pacing of the matrix refresh.

---
 rtl/matrix_frame_scheduler.sv | 116 +++++++++++
 1 files changed

// File: rtl/matrix_frame_scheduler.sv
// matrix_frame_scheduler: walks a buffered frame column by column, word by word, pacing the SPI output stage.
// Define SCHED_FRAME_REPEAT_EN to refresh the last frame continuously instead of idling.
module matrix_frame_scheduler #(
    parameter int CHANNEL_NUMBER = 3,
    parameter int SPI_SIZE       = 24,
    parameter int COLUMNS        = 16,
    parameter int ROWS           = 8,
    parameter int ADDR_W         = $clog2(COLUMNS*ROWS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               frame_ready,
    output logic                               frame_done,
    output logic                               busy,
    output logic                               buf_rd_en,
    output logic [ADDR_W-1:0]                  buf_rd_addr,
    input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] buf_rd_data,
    output logic [CHANNEL_NUMBER*SPI_SIZE-1:0] data_in,
    output logic                               data_valid,
    output logic                               extra_bit,
    output logic                               new_image,
    output logic                               new_column,
    input  logic                               next_data,
    input  logic                               tx_finish
);
    localparam int W  = CHANNEL_NUMBER*SPI_SIZE;
    localparam int CW = COLUMNS > 1 ? $clog2(COLUMNS) : 1;
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;

    typedef enum logic [3:0] {
        IDLE, IMG_START, COL_START, FETCH, LOAD, SEND, WAIT_NEXT, WAIT_FIN, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          pend_q, pend_d;
    logic [W-1:0]  data_q;
    logic          last_row, last_col;

    assign last_row = row_q == RW'(ROWS-1);
    assign last_col = col_q == CW'(COLUMNS-1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pend_q  <= pend_d;
            if (state_q == LOAD) data_q <= buf_rd_data;
        end
    end

    // A frame_ready arriving while busy is remembered once; IDLE consumes it.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        pend_d  = pend_q | frame_ready;
        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (frame_ready || pend_q) state_d = IMG_START;
            end
            IMG_START: begin
                col_d   = '0;
                row_d   = '0;
                state_d = COL_START;
            end
            COL_START: state_d = FETCH;
            FETCH:     state_d = LOAD;
            LOAD:      state_d = SEND;
            SEND:      state_d = WAIT_NEXT;
            WAIT_NEXT: if (next_data) begin
                if (last_row) state_d = WAIT_FIN;
                else begin
                    row_d   = row_q + 1'b1;
                    state_d = FETCH;
                end
            end
            WAIT_FIN: if (tx_finish) begin
                if (last_col) state_d = DONE;
                else begin
                    col_d   = col_q + 1'b1;
                    row_d   = '0;
                    state_d = COL_START;
                end
            end
`ifdef SCHED_FRAME_REPEAT_EN
            DONE: begin
                pend_d  = 1'b0;
                state_d = IMG_START;
            end
`else
            DONE: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    assign busy        = state_q != IDLE;
    assign new_image   = state_q == IMG_START;
    assign new_column  = state_q == COL_START;
    assign buf_rd_en   = state_q == FETCH;
    assign buf_rd_addr = ADDR_W'(col_q) * ADDR_W'(ROWS) + ADDR_W'(row_q);
    assign data_valid  = state_q == SEND;
    assign extra_bit   = (state_q == SEND) && last_row;
    assign frame_done  = state_q == DONE;
    assign data_in     = data_q;
endmodule
